controlador_frequencia_contador: RTL and testbench

//  Sequencer for the variable-frequency 4-bit count path. Generates the count tick

---
 rtl/controlador_frequencia_contador.sv | 174 +++++++++++++++++
 tb/tb_controlador_frequencia_contador.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_frequencia_contador.sv
// controlador_frequencia_contador
// Sequencer for the variable-frequency 4-bit count path. Divides the board clock
// to one of four tick rates, owns the count value S, and supports start/pause and
// an automatic mode that steps to the next rate each time the count wraps.
module controlador_frequencia_contador #(
  parameter int unsigned DIV_0    = 50_000_000,
  parameter int unsigned DIV_1    = 25_000_000,
  parameter int unsigned DIV_2    = 12_500_000,
  parameter int unsigned DIV_3    = 6_250_000,
  parameter int unsigned LARG_DIV = 26,
  parameter int unsigned LIMITE   = 15
) (
  input  logic       clock_inicial,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       modo_auto,
  input  logic       chave_A,
  input  logic       chave_B,
  output logic [3:0] S,
  output logic [1:0] selecao,
  output logic       pulso_contagem,
  output logic       fim_ciclo,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    CONTANDO = 2'b01,
    PAUSADO  = 2'b10,
    TROCA    = 2'b11
  } estado_t;

  localparam logic [LARG_DIV-1:0] FIM_0 = LARG_DIV'(DIV_0 - 1);
  localparam logic [LARG_DIV-1:0] FIM_1 = LARG_DIV'(DIV_1 - 1);
  localparam logic [LARG_DIV-1:0] FIM_2 = LARG_DIV'(DIV_2 - 1);
  localparam logic [LARG_DIV-1:0] FIM_3 = LARG_DIV'(DIV_3 - 1);
  localparam logic [3:0]          LIMITE_S = 4'(LIMITE);

  estado_t             estado_atual;
  estado_t             estado_prox;
  logic                iniciar_r;
  logic                iniciar_ant;
  logic                pausar_r;
  logic                pausar_ant;
  logic                modo_r;
  logic [1:0]          chave_r;
  logic [1:0]          sel_auto;
  logic [1:0]          sel_alvo;
  logic [1:0]          sel_prox;
  logic                iniciar_borda;
  logic                pausar_borda;
  logic                troca_necessaria;
  logic [LARG_DIV-1:0] prescaler;
  logic [LARG_DIV-1:0] prescaler_prox;
  logic [LARG_DIV-1:0] div_fim;
  logic [3:0]          s_prox;
  logic                pulso_prox;
  logic                fim_prox;

  // Register the control inputs; reset preloads both stages so a held input gives no edge
  always_ff @(posedge clock_inicial) begin
    if (reset) begin
      iniciar_r   <= iniciar;
      iniciar_ant <= iniciar;
      pausar_r    <= pausar;
      pausar_ant  <= pausar;
      modo_r      <= modo_auto;
      chave_r     <= {chave_B, chave_A};
    end else begin
      iniciar_r   <= iniciar;
      iniciar_ant <= iniciar_r;
      pausar_r    <= pausar;
      pausar_ant  <= pausar_r;
      modo_r      <= modo_auto;
      chave_r     <= {chave_B, chave_A};
    end
  end

  assign iniciar_borda    = iniciar_r & ~iniciar_ant;
  assign pausar_borda     = pausar_r & ~pausar_ant;
  assign sel_alvo         = modo_r ? sel_auto : chave_r;
  assign troca_necessaria = (sel_alvo != selecao);
  assign estado           = estado_atual;

  // Terminal prescaler count for the rate currently in force
  always_comb begin
    div_fim = FIM_0;
    case (selecao)
      2'b00:   div_fim = FIM_0;
      2'b01:   div_fim = FIM_1;
      2'b10:   div_fim = FIM_2;
      default: div_fim = FIM_3;
    endcase
  end

  // State register
  always_ff @(posedge clock_inicial) begin
    if (reset) estado_atual <= OCIOSO;
    else       estado_atual <= estado_prox;
  end

  // Next-state logic; a pause edge always beats a start edge, and a rate change beats a tick
  always_comb begin
    estado_prox = estado_atual;
    case (estado_atual)
      OCIOSO:   if (iniciar_borda && !pausar_borda) estado_prox = CONTANDO;
      CONTANDO: begin
        if (pausar_borda)          estado_prox = PAUSADO;
        else if (troca_necessaria) estado_prox = TROCA;
      end
      PAUSADO:  if (iniciar_borda && !pausar_borda) estado_prox = CONTANDO;
      default:  estado_prox = CONTANDO;
    endcase
  end

  // Next values for prescaler, count, rate and the one-cycle pulses
  always_comb begin
    prescaler_prox = prescaler;
    s_prox         = S;
    sel_prox       = selecao;
    pulso_prox     = 1'b0;
    fim_prox       = 1'b0;
    case (estado_atual)
      OCIOSO: begin
        if (estado_prox == CONTANDO) prescaler_prox = '0;
      end
      CONTANDO: begin
        if (estado_prox == CONTANDO) begin
          if (prescaler == div_fim) begin
            prescaler_prox = '0;
            pulso_prox     = 1'b1;
            if (S == LIMITE_S) begin
              s_prox   = 4'd0;
              fim_prox = 1'b1;
            end else begin
              s_prox = S + 4'd1;
            end
          end else begin
            prescaler_prox = prescaler + 1'b1;
          end
        end
      end
      PAUSADO: begin
        prescaler_prox = prescaler;
      end
      default: begin
        prescaler_prox = '0;
        sel_prox       = sel_alvo;
      end
    endcase
  end

  // Datapath registers; the auto-mode target follows the live rate until a wrap steps it
  always_ff @(posedge clock_inicial) begin
    if (reset) begin
      prescaler      <= '0;
      S              <= 4'd0;
      selecao        <= 2'b00;
      pulso_contagem <= 1'b0;
      fim_ciclo      <= 1'b0;
      sel_auto       <= 2'b00;
    end else begin
      prescaler      <= prescaler_prox;
      S              <= s_prox;
      selecao        <= sel_prox;
      pulso_contagem <= pulso_prox;
      fim_ciclo      <= fim_prox;
      if (!modo_r)       sel_auto <= sel_prox;
      else if (fim_prox) sel_auto <= selecao + 2'd1;
    end
  end

endmodule

// File: tb/tb_controlador_frequencia_contador.sv
// Directed bench for controlador_frequencia_contador with divisors 4,3,2,1 and LIMITE 15.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_controlador_frequencia_contador;

  logic       clk;
  logic       reset;
  logic       iniciar;
  logic       pausar;
  logic       modo_auto;
  logic       chave_A;
  logic       chave_B;
  logic [3:0] S;
  logic [1:0] selecao;
  logic       pulso_contagem;
  logic       fim_ciclo;
  logic [1:0] estado;

  int errors = 0;
  int checks = 0;

  controlador_frequencia_contador #(
    .DIV_0(4), .DIV_1(3), .DIV_2(2), .DIV_3(1), .LARG_DIV(26), .LIMITE(15)
  ) dut (
    .clock_inicial (clk),
    .reset         (reset),
    .iniciar       (iniciar),
    .pausar        (pausar),
    .modo_auto     (modo_auto),
    .chave_A       (chave_A),
    .chave_B       (chave_B),
    .S             (S),
    .selecao       (selecao),
    .pulso_contagem(pulso_contagem),
    .fim_ciclo     (fim_ciclo),
    .estado        (estado)
  );

  // Free-running board clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic rst, input logic ini, input logic pau,
                                input logic auto_m, input logic [1:0] chaves);
    reset     = rst;
    iniciar   = ini;
    pausar    = pau;
    modo_auto = auto_m;
    {chave_B, chave_A} = chaves;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Directed sequence with hand-computed expectations
  initial begin
    // reset held three cycles with iniciar high
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    wait_cycles(3);
    check_output("reset_S", 8'(S), 8'd0);
    check_output("reset_estado", 8'(estado), 8'd0);
    check_output("reset_selecao", 8'(selecao), 8'd0);
    check_output("reset_pulso", 8'(pulso_contagem), 8'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    wait_cycles(3);
    check_output("held_iniciar_no_start", 8'(estado), 8'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    wait_cycles(2);
    check_output("dropped_iniciar_idle", 8'(estado), 8'd0);

    // manual rate 00, start and count a full cycle
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    wait_cycles(1);
    check_output("start_latency_idle", 8'(estado), 8'd0);
    wait_cycles(1);
    check_output("start_contando", 8'(estado), 8'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    wait_cycles(3);
    check_output("pre_tick_S", 8'(S), 8'd0);
    check_output("pre_tick_pulso", 8'(pulso_contagem), 8'd0);
    wait_cycles(1);
    check_output("tick1_S", 8'(S), 8'd1);
    check_output("tick1_pulso", 8'(pulso_contagem), 8'd1);
    for (int k = 2; k <= 15; k++) begin
      wait_cycles(4);
      check_output("rate00_S", 8'(S), 8'(k));
      check_output("rate00_pulso", 8'(pulso_contagem), 8'd1);
      check_output("rate00_fim", 8'(fim_ciclo), 8'd0);
    end
    wait_cycles(4);
    check_output("wrap_S", 8'(S), 8'd0);
    check_output("wrap_fim", 8'(fim_ciclo), 8'd1);
    check_output("wrap_pulso", 8'(pulso_contagem), 8'd1);
    wait_cycles(1);
    check_output("wrap_fim_one_cycle", 8'(fim_ciclo), 8'd0);
    check_output("wrap_pulso_one_cycle", 8'(pulso_contagem), 8'd0);

    // pause at S=5 one cycle into the period, then resume
    wait_cycles(19);
    check_output("pre_pause_S", 8'(S), 8'd5);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    wait_cycles(2);
    check_output("paused_estado", 8'(estado), 8'd2);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    wait_cycles(20);
    check_output("paused_S_frozen", 8'(S), 8'd5);
    check_output("paused_still", 8'(estado), 8'd2);
    check_output("paused_no_pulso", 8'(pulso_contagem), 8'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    wait_cycles(2);
    check_output("resume_estado", 8'(estado), 8'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    wait_cycles(2);
    check_output("resume_before_tick", 8'(S), 8'd5);
    wait_cycles(1);
    check_output("resume_partial_tick_S", 8'(S), 8'd6);
    check_output("resume_partial_tick_pulso", 8'(pulso_contagem), 8'd1);

    // simultaneous start and pause edges
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    wait_cycles(2);
    check_output("both_edges_contando", 8'(estado), 8'd2);
    check_output("both_edges_S", 8'(S), 8'd6);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    wait_cycles(1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_output("rst2_estado", 8'(estado), 8'd0);
    check_output("rst2_S", 8'(S), 8'd0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    wait_cycles(2);
    check_output("both_edges_ocioso", 8'(estado), 8'd0);
    wait_cycles(2);
    check_output("both_edges_ocioso_later", 8'(estado), 8'd0);

    // automatic rate stepping
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    wait_cycles(2);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    wait_cycles(2);
    check_output("auto_start", 8'(estado), 8'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    wait_cycles(64);
    check_output("auto_wrap0_fim", 8'(fim_ciclo), 8'd1);
    check_output("auto_wrap0_sel", 8'(selecao), 8'd0);
    wait_cycles(1);
    check_output("auto_troca0", 8'(estado), 8'd3);
    check_output("auto_troca0_pulso", 8'(pulso_contagem), 8'd0);
    wait_cycles(1);
    check_output("auto_sel01", 8'(selecao), 8'd1);
    check_output("auto_sel01_estado", 8'(estado), 8'd1);
    wait_cycles(2);
    check_output("auto_r01_gap", 8'(pulso_contagem), 8'd0);
    wait_cycles(1);
    check_output("auto_r01_tick", 8'(pulso_contagem), 8'd1);
    check_output("auto_r01_S", 8'(S), 8'd1);
    wait_cycles(45);
    check_output("auto_wrap1_fim", 8'(fim_ciclo), 8'd1);
    check_output("auto_wrap1_S", 8'(S), 8'd0);
    wait_cycles(1);
    check_output("auto_troca1", 8'(estado), 8'd3);
    wait_cycles(1);
    check_output("auto_sel10", 8'(selecao), 8'd2);
    wait_cycles(1);
    check_output("auto_r10_gap", 8'(pulso_contagem), 8'd0);
    wait_cycles(1);
    check_output("auto_r10_tick", 8'(S), 8'd1);
    wait_cycles(30);
    check_output("auto_wrap2_fim", 8'(fim_ciclo), 8'd1);
    wait_cycles(1);
    check_output("auto_troca2", 8'(estado), 8'd3);
    wait_cycles(1);
    check_output("auto_sel11", 8'(selecao), 8'd3);
    check_output("auto_sel11_pulso", 8'(pulso_contagem), 8'd0);
    wait_cycles(1);
    check_output("auto_r11_tick1", 8'(S), 8'd1);
    wait_cycles(1);
    check_output("auto_r11_tick2", 8'(S), 8'd2);
    check_output("auto_r11_pulso", 8'(pulso_contagem), 8'd1);
    wait_cycles(14);
    check_output("auto_wrap3_fim", 8'(fim_ciclo), 8'd1);
    wait_cycles(1);
    check_output("auto_troca3", 8'(estado), 8'd3);
    check_output("auto_troca3_pulso", 8'(pulso_contagem), 8'd0);
    wait_cycles(1);
    check_output("auto_sel00_again", 8'(selecao), 8'd0);

    // manual switch change mid-count, then reset mid-count
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    wait_cycles(36);
    check_output("manual_S9", 8'(S), 8'd9);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    wait_cycles(1);
    check_output("switch_latency", 8'(estado), 8'd1);
    wait_cycles(1);
    check_output("switch_troca", 8'(estado), 8'd3);
    check_output("switch_troca_S", 8'(S), 8'd9);
    check_output("switch_troca_sel", 8'(selecao), 8'd0);
    wait_cycles(1);
    check_output("switch_sel11", 8'(selecao), 8'd3);
    check_output("switch_after_S", 8'(S), 8'd9);
    wait_cycles(1);
    check_output("switch_tick_S10", 8'(S), 8'd10);
    wait_cycles(1);
    check_output("switch_tick_S11", 8'(S), 8'd11);
    check_output("switch_tick_pulso", 8'(pulso_contagem), 8'd1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
    wait_cycles(1);
    check_output("midreset_S", 8'(S), 8'd0);
    check_output("midreset_estado", 8'(estado), 8'd0);
    check_output("midreset_sel", 8'(selecao), 8'd0);
    check_output("midreset_pulso", 8'(pulso_contagem), 8'd0);
    check_output("midreset_fim", 8'(fim_ciclo), 8'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    wait_cycles(2);
    check_output("post_reset_idle", 8'(estado), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
